// File: rtl/mac_dot_pipe.sv
// rtl/mac_dot_pipe.sv - pipelined N-lane dot-product MAC with frame accumulation and ready/valid output
// Optional accumulator saturation: define MAC_DOT_PIPE_SAT_EN.
module mac_dot_pipe #(
  parameter int N_LANES = 16,
  parameter int IN_W    = 16,
  parameter int ACC_W   = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic                    in_signed,
  input  logic [N_LANES*IN_W-1:0] a_vec,
  input  logic [N_LANES*IN_W-1:0] b_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic                    out_sat
);

  localparam int L  = $clog2(N_LANES);
  localparam int PW = 2 * IN_W;
  localparam int TW = PW + L;

  logic stall;
  logic accept;
  logic out_valid_d, out_valid_q;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && !stall;

  // Operands are extended to the full product width so the low PW bits equal the signed or unsigned product.
  function automatic logic [PW-1:0] lane_mul(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                                             input logic s);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    ax = {{IN_W{s & a[IN_W-1]}}, a};
    bx = {{IN_W{s & b[IN_W-1]}}, b};
    return ax * bx;
  endfunction

  // Index 0 is stage M, index k is tree level k.
  logic [L:0] vld_d, vld_q;
  logic [L:0] lst_d, lst_q;
  logic [L:0] sgn_d, sgn_q;

  always_comb begin
    vld_d = {vld_q[L-1:0], accept};
    lst_d = {lst_q[L-1:0], in_last};
    sgn_d = {sgn_q[L-1:0], in_signed};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      lst_q <= '0;
      sgn_q <= '0;
    end else if (!stall) begin
      vld_q <= vld_d;
      lst_q <= lst_d;
      sgn_q <= sgn_d;
    end
  end

  for (genvar k = 0; k <= L; k++) begin : g_lvl
    localparam int W   = PW + k;
    localparam int CNT = N_LANES >> k;
    logic [CNT*W-1:0] sum_d, sum_q;

    if (k == 0) begin : g_mul
      always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_LANES; i++) begin
          sum_d[i*W +: W] = lane_mul(a_vec[i*IN_W +: IN_W], b_vec[i*IN_W +: IN_W], in_signed);
        end
      end
    end else begin : g_add
      logic [W-2:0] x, y;
      always_comb begin
        sum_d = '0;
        x     = '0;
        y     = '0;
        for (int j = 0; j < CNT; j++) begin
          x = g_lvl[k-1].sum_q[(2*j)*(W-1) +: W-1];
          y = g_lvl[k-1].sum_q[(2*j+1)*(W-1) +: W-1];
          sum_d[j*W +: W] = {sgn_q[k-1] & x[W-2], x} + {sgn_q[k-1] & y[W-2], y};
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
      end else if (!stall) begin
        sum_q <= sum_d;
      end
    end
  end

  logic [TW-1:0]    tree_sum;
  logic [ACC_W-1:0] tree_ext;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_new;
  logic             clamp;
  logic             sat_new;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             first_d, first_q;
  logic             sat_acc_d, sat_acc_q;
  logic [ACC_W-1:0] out_data_d, out_data_q;
  logic             out_sat_d, out_sat_q;

  assign tree_sum = g_lvl[L].sum_q;

  always_comb begin
    if (sgn_q[L]) tree_ext = ACC_W'($signed(tree_sum));
    else          tree_ext = ACC_W'(tree_sum);
    acc_base = first_q ? '0 : acc_q;
`ifdef MAC_DOT_PIPE_SAT_EN
    begin : sat_add
      logic [ACC_W:0] sum_x;
      sum_x   = {sgn_q[L] & acc_base[ACC_W-1], acc_base} + {sgn_q[L] & tree_ext[ACC_W-1], tree_ext};
      clamp   = 1'b0;
      acc_new = sum_x[ACC_W-1:0];
      if (sgn_q[L]) begin
        if (sum_x[ACC_W] != sum_x[ACC_W-1]) begin
          clamp   = 1'b1;
          acc_new = sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
      end else if (sum_x[ACC_W]) begin
        clamp   = 1'b1;
        acc_new = '1;
      end
    end
`else
    clamp   = 1'b0;
    acc_new = acc_base + tree_ext;
`endif
    sat_new = (!first_q && sat_acc_q) || clamp;
  end

  always_comb begin
    acc_d       = acc_q;
    first_d     = first_q;
    sat_acc_d   = sat_acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sat_d   = out_sat_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    // A new result may land in the same cycle the previous one is taken.
    if (!stall && vld_q[L]) begin
      if (lst_q[L]) begin
        out_data_d  = acc_new;
        out_sat_d   = sat_new;
        out_valid_d = 1'b1;
        first_d     = 1'b1;
      end else begin
        acc_d     = acc_new;
        sat_acc_d = sat_new;
        first_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      sat_acc_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      first_q     <= first_d;
      sat_acc_q   <= sat_acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_dot_pipe.sv
// tb/tb_mac_dot_pipe.sv - directed self-checking bench for mac_dot_pipe
module tb_mac_dot_pipe;

  localparam int N   = 16;
  localparam int IW  = 16;
  localparam int AW  = 40;
  localparam int AW2 = 36;
  localparam int VW  = N * IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_valid2 = 1'b0;
  logic          in_last = 1'b0;
  logic          in_signed = 1'b0;
  logic          out_ready = 1'b1;
  logic          out_ready2 = 1'b1;
  logic [VW-1:0] a_vec = '0;
  logic [VW-1:0] b_vec = '0;
  logic          in_ready, out_valid, out_sat;
  logic [AW-1:0] out_data;
  logic          in_ready2, out_valid2, out_sat2;
  logic [AW2-1:0] out_data2;

  int n_checks = 0;
  int n_fails  = 0;
  logic [AW:0]  q1[$];
  logic [AW2:0] q2[$];

  always #5 clk = ~clk;

  mac_dot_pipe #(.N_LANES(N), .IN_W(IW), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_signed(in_signed), .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  mac_dot_pipe #(.N_LANES(N), .IN_W(IW), .ACC_W(AW2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_last(in_last),
    .in_signed(in_signed), .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_data(out_data2), .out_sat(out_sat2)
  );

  always @(negedge clk) begin
    if (out_valid && out_ready) q1.push_back({out_sat, out_data});
    if (out_valid2 && out_ready2) q2.push_back({out_sat2, out_data2});
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [IW-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*IW +: IW] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] ramp(input int base);
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*IW +: IW] = IW'(base + i);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit sel, input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input logic last, input logic sgn);
    logic rdy;
    bit   done;
    a_vec = a;
    b_vec = b;
    in_last = last;
    in_signed = sgn;
    if (sel) in_valid2 = 1'b1;
    else     in_valid  = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      rdy = sel ? in_ready2 : in_ready;
      @(posedge clk);
      #1;
      done = rdy;
    end
    check_eq("send_accept", 64'(done), 64'd1);
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [AW-1:0] d, input logic s);
    logic [AW:0] r;
    for (int t = 0; t < 60 && q1.size() == 0; t++) tick(1);
    check_eq({tag, "_avail"}, 64'(q1.size() != 0), 64'd1);
    if (q1.size() != 0) begin
      r = q1.pop_front();
      check_eq({tag, "_data"}, 64'(r[AW-1:0]), 64'(d));
      check_eq({tag, "_sat"}, 64'(r[AW]), 64'(s));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int early;
    logic [AW2:0]   r2;
    logic [AW2-1:0] exp2;
    logic           exps2;

    #12;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_sat", 64'(out_sat), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Single unsigned beat: latency counted from the edge the beat is driven after.
    a_vec = fill(16'd3);
    b_vec = fill(16'd5);
    in_last = 1'b1;
    in_signed = 1'b0;
    in_valid = 1'b1;
    lat = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      lat++;
      in_valid = 1'b0;
      if (out_valid) break;
    end
    check_eq("latency", 64'(lat), 64'd6);
    expect_res("t1_unsigned", 40'd240, 1'b0);

    send(0, fill(16'hFFFE), fill(16'd7), 1'b1, 1'b1);
    expect_res("t2_signed", 40'hFF_FFFF_FF20, 1'b0);
    send(0, ramp(-8), fill(16'd3), 1'b1, 1'b1);
    expect_res("t2_signed_ramp", 40'hFF_FFFF_FFE8, 1'b0);
    send(0, fill(16'h8000), fill(16'h8000), 1'b1, 1'b1);
    expect_res("t2_signed_min", 40'h04_0000_0000, 1'b0);
    send(0, fill(16'hFFFF), fill(16'hFFFF), 1'b1, 1'b0);
    expect_res("t2_unsigned_max", 40'h0F_FFE0_0010, 1'b0);
    send(0, fill(16'hFFFF), fill(16'hFFFF), 1'b1, 1'b1);
    expect_res("t2_signed_m1", 40'd16, 1'b0);

    // Three-beat frame.
    send(0, ramp(0), fill(16'd1), 1'b0, 1'b0);
    send(0, ramp(0), fill(16'd1), 1'b0, 1'b0);
    early = 0;
    repeat (10) begin
      tick(1);
      if (out_valid) early++;
    end
    check_eq("t3_no_early", 64'(early), 64'd0);
    send(0, ramp(0), fill(16'd1), 1'b1, 1'b0);
    expect_res("t3_three_beat", 40'd360, 1'b0);

    // Backpressure: frames enter before the first result lands, then stay frozen.
    out_ready = 1'b0;
    send(0, fill(16'd1), fill(16'd2), 1'b1, 1'b0);
    send(0, fill(16'd2), fill(16'd2), 1'b0, 1'b0);
    send(0, ramp(0), fill(16'd2), 1'b1, 1'b0);
    send(0, fill(16'hFFFF), fill(16'hFFFF), 1'b1, 1'b1);
    tick(10);
    check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    check_eq("bp_out_valid", 64'(out_valid), 64'd1);
    check_eq("bp_hold_data", 64'(out_data), 64'd32);
    tick(3);
    check_eq("bp_hold_data2", 64'(out_data), 64'd32);
    check_eq("bp_no_pop", 64'(q1.size()), 64'd0);
    out_ready = 1'b1;
    expect_res("bp_a", 40'd32, 1'b0);
    expect_res("bp_b", 40'd304, 1'b0);
    expect_res("bp_c", 40'd16, 1'b0);
    tick(10);
    check_eq("bp_no_dup", 64'(q1.size()), 64'd0);
    check_eq("bp_idle_valid", 64'(out_valid), 64'd0);

    // Reset mid-frame discards the partial accumulation.
    send(0, fill(16'd5), fill(16'd5), 1'b0, 1'b0);
    send(0, fill(16'd5), fill(16'd5), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_data", 64'(out_data), 64'd0);
    tick(2);
    rst_n = 1'b1;
    send(0, fill(16'd1), fill(16'd1), 1'b1, 1'b0);
    expect_res("post_rst", 40'd16, 1'b0);
    tick(10);
    check_eq("post_rst_no_extra", 64'(q1.size()), 64'd0);

    // 36-bit accumulator driven past its range.
    for (int i = 0; i < 8; i++) send(1, fill(16'hFFFF), fill(16'hFFFF), (i == 7), 1'b0);
`ifdef MAC_DOT_PIPE_SAT_EN
    exp2  = '1;
    exps2 = 1'b1;
`else
    exp2  = AW2'(128 * 64'hFFFE_0001);
    exps2 = 1'b0;
`endif
    for (int t = 0; t < 60 && q2.size() == 0; t++) tick(1);
    check_eq("acc36_avail", 64'(q2.size() != 0), 64'd1);
    if (q2.size() != 0) begin
      r2 = q2.pop_front();
      check_eq("acc36_data", 64'(r2[AW2-1:0]), 64'(exp2));
      check_eq("acc36_sat", 64'(r2[AW2]), 64'(exps2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
